// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
//   Pipeline register between instruction decode (ID) and execute (EX) of the
//   5-stage ARM-subset core. Each rising edge it captures the decoded control
//   bundle, operands, immediates, destination and the C flag.
//
//   Update priority per edge: rst > flush > freeze > load.
//     rst    : every *_out, valid_out and bubble_count go to 0
//     flush  : every *_out and valid_out go to 0, bubble_count += 1 (saturating)
//     freeze : everything holds
//     load   : every *_out takes its *_in, valid_out = 1, bubble_count holds
//
//   There is no handshake on this register: the hazard unit owns freeze and
//   the branch logic owns flush, and both are honoured on the same edge.
//
//   Optional build macro: ID_EX_FORWARD_SRC_EN
//     defined   : src1_out / src2_out are registered like every other field
//     undefined : no src registers exist, src1_out / src2_out are tied to 0
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   flush, freeze                 bubble insertion / hold
//   pc_in ... carry_in            ID-stage values to capture
//   pc_out ... carry_out          registered copies (one-cycle latency)
//   valid_out                     1 = real instruction, 0 = bubble
//   bubble_count                  saturating count of flush-inserted bubbles
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int WORD_WIDTH            = 32,
  parameter int REG_FILE_DEPTH        = 4,
  parameter int SIGNED_IMM_WIDTH      = 24,
  parameter int SHIFTER_OPERAND_WIDTH = 12,
  parameter int BUBBLE_CNT_WIDTH      = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             freeze,
  input  logic [WORD_WIDTH-1:0]            pc_in,
  input  logic [WORD_WIDTH-1:0]            instruction_in,
  input  logic [REG_FILE_DEPTH-1:0]        reg_file_dst_in,
  input  logic [REG_FILE_DEPTH-1:0]        src1_in,
  input  logic [REG_FILE_DEPTH-1:0]        src2_in,
  input  logic [WORD_WIDTH-1:0]            val_Rn_in,
  input  logic [WORD_WIDTH-1:0]            val_Rm_in,
  input  logic [SIGNED_IMM_WIDTH-1:0]      signed_immediate_in,
  input  logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand_in,
  input  logic [3:0]                       EX_command_in,
  input  logic                             mem_read_in,
  input  logic                             mem_write_in,
  input  logic                             WB_en_in,
  input  logic                             Imm_in,
  input  logic                             B_in,
  input  logic                             SR_update_in,
  input  logic                             carry_in,
  output logic [WORD_WIDTH-1:0]            pc_out,
  output logic [WORD_WIDTH-1:0]            instruction_out,
  output logic [REG_FILE_DEPTH-1:0]        reg_file_dst_out,
  output logic [REG_FILE_DEPTH-1:0]        src1_out,
  output logic [REG_FILE_DEPTH-1:0]        src2_out,
  output logic [WORD_WIDTH-1:0]            val_Rn_out,
  output logic [WORD_WIDTH-1:0]            val_Rm_out,
  output logic [SIGNED_IMM_WIDTH-1:0]      signed_immediate_out,
  output logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand_out,
  output logic [3:0]                       EX_command_out,
  output logic                             mem_read_out,
  output logic                             mem_write_out,
  output logic                             WB_en_out,
  output logic                             Imm_out,
  output logic                             B_out,
  output logic                             SR_update_out,
  output logic                             carry_out,
  output logic                             valid_out,
  output logic [BUBBLE_CNT_WIDTH-1:0]      bubble_count
);

  logic [WORD_WIDTH-1:0]            r_pc;
  logic [WORD_WIDTH-1:0]            r_instruction;
  logic [REG_FILE_DEPTH-1:0]        r_reg_file_dst;
  logic [WORD_WIDTH-1:0]            r_val_Rn;
  logic [WORD_WIDTH-1:0]            r_val_Rm;
  logic [SIGNED_IMM_WIDTH-1:0]      r_signed_immediate;
  logic [SHIFTER_OPERAND_WIDTH-1:0] r_shifter_operand;
  logic [3:0]                       r_EX_command;
  logic                             r_mem_read;
  logic                             r_mem_write;
  logic                             r_WB_en;
  logic                             r_Imm;
  logic                             r_B;
  logic                             r_SR_update;
  logic                             r_carry;
  logic                             r_valid;
  logic [BUBBLE_CNT_WIDTH-1:0]      r_bubble_count;

  // Counter is at all-ones: further flushes must leave it unchanged.
  logic w_bubble_sat;
  assign w_bubble_sat = &r_bubble_count;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      // Bubbles zero data fields too so that a bubble is fully deterministic.
      r_pc               <= '0;
      r_instruction      <= '0;
      r_reg_file_dst     <= '0;
      r_val_Rn           <= '0;
      r_val_Rm           <= '0;
      r_signed_immediate <= '0;
      r_shifter_operand  <= '0;
      r_EX_command       <= '0;
      r_mem_read         <= 1'b0;
      r_mem_write        <= 1'b0;
      r_WB_en            <= 1'b0;
      r_Imm              <= 1'b0;
      r_B                <= 1'b0;
      r_SR_update        <= 1'b0;
      r_carry            <= 1'b0;
      r_valid            <= 1'b0;
      if (rst) begin
        r_bubble_count <= '0;
      end else if (!w_bubble_sat) begin
        r_bubble_count <= r_bubble_count + 1'b1;
      end
    end else if (!freeze) begin
      // Condition-failed instructions arrive with zeroed control bits and are
      // loaded as-is with valid set; no reinterpretation happens here.
      r_pc               <= pc_in;
      r_instruction      <= instruction_in;
      r_reg_file_dst     <= reg_file_dst_in;
      r_val_Rn           <= val_Rn_in;
      r_val_Rm           <= val_Rm_in;
      r_signed_immediate <= signed_immediate_in;
      r_shifter_operand  <= shifter_operand_in;
      r_EX_command       <= EX_command_in;
      r_mem_read         <= mem_read_in;
      r_mem_write        <= mem_write_in;
      r_WB_en            <= WB_en_in;
      r_Imm              <= Imm_in;
      r_B                <= B_in;
      r_SR_update        <= SR_update_in;
      r_carry            <= carry_in;
      r_valid            <= 1'b1;
    end
  end

`ifdef ID_EX_FORWARD_SRC_EN
  // Source addresses feed the forwarding unit's MEM/WB destination compare.
  logic [REG_FILE_DEPTH-1:0] r_src1;
  logic [REG_FILE_DEPTH-1:0] r_src2;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_src1 <= '0;
      r_src2 <= '0;
    end else if (!freeze) begin
      r_src1 <= src1_in;
      r_src2 <= src2_in;
    end
  end

  assign src1_out = r_src1;
  assign src2_out = r_src2;
`else
  // Forwarding disabled: source addresses are not stored.
  logic w_unused_src;
  assign w_unused_src = ^{src1_in, src2_in};
  assign src1_out     = '0;
  assign src2_out     = '0;
`endif

  assign pc_out               = r_pc;
  assign instruction_out      = r_instruction;
  assign reg_file_dst_out     = r_reg_file_dst;
  assign val_Rn_out           = r_val_Rn;
  assign val_Rm_out           = r_val_Rm;
  assign signed_immediate_out = r_signed_immediate;
  assign shifter_operand_out  = r_shifter_operand;
  assign EX_command_out       = r_EX_command;
  assign mem_read_out         = r_mem_read;
  assign mem_write_out        = r_mem_write;
  assign WB_en_out            = r_WB_en;
  assign Imm_out              = r_Imm;
  assign B_out                = r_B;
  assign SR_update_out        = r_SR_update;
  assign carry_out            = r_carry;
  assign valid_out            = r_valid;
  assign bubble_count         = r_bubble_count;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage_reg
//   Directed scoreboard bench for id_ex_stage_reg. Two instances share the
//   same stimulus: the default one (16-bit bubble counter) and a 2-bit
//   counter instance used for saturation. The driver updates a reference
//   state with the rst > flush > freeze > load rules and pushes the expected
//   output bundle each cycle; the monitor pops and compares after each edge.
// ---------------------------------------------------------------------------
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  dst;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [23:0] simm;
    logic [11:0] shop;
    logic [3:0]  ex;
    logic        mr;
    logic        mw;
    logic        wb;
    logic        imm;
    logic        b;
    logic        sr;
    logic        c;
  } fields_t;

  localparam int BW = $bits(fields_t) + 1 + 16 + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic    rst    = 1'b1;
  logic    flush  = 1'b0;
  logic    freeze = 1'b0;
  fields_t in_f   = '0;

  // ---------------- DUT outputs ----------------
  logic [31:0] pc_out, instruction_out, val_Rn_out, val_Rm_out;
  logic [3:0]  reg_file_dst_out, src1_out, src2_out, EX_command_out;
  logic [23:0] signed_immediate_out;
  logic [11:0] shifter_operand_out;
  logic        mem_read_out, mem_write_out, WB_en_out, Imm_out, B_out;
  logic        SR_update_out, carry_out, valid_out;
  logic [15:0] bubble_count;

  logic [31:0] s_pc, s_instr, s_rn, s_rm;
  logic [3:0]  s_dst, s_s1, s_s2, s_ex;
  logic [23:0] s_simm;
  logic [11:0] s_shop;
  logic        s_mr, s_mw, s_wb, s_imm, s_b, s_sr, s_c, s_valid;
  logic [1:0]  s_bubble_count;

  id_ex_stage_reg u_dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .pc_in(in_f.pc), .instruction_in(in_f.instr), .reg_file_dst_in(in_f.dst),
    .src1_in(in_f.s1), .src2_in(in_f.s2), .val_Rn_in(in_f.rn), .val_Rm_in(in_f.rm),
    .signed_immediate_in(in_f.simm), .shifter_operand_in(in_f.shop),
    .EX_command_in(in_f.ex), .mem_read_in(in_f.mr), .mem_write_in(in_f.mw),
    .WB_en_in(in_f.wb), .Imm_in(in_f.imm), .B_in(in_f.b), .SR_update_in(in_f.sr),
    .carry_in(in_f.c),
    .pc_out(pc_out), .instruction_out(instruction_out),
    .reg_file_dst_out(reg_file_dst_out), .src1_out(src1_out), .src2_out(src2_out),
    .val_Rn_out(val_Rn_out), .val_Rm_out(val_Rm_out),
    .signed_immediate_out(signed_immediate_out),
    .shifter_operand_out(shifter_operand_out), .EX_command_out(EX_command_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .WB_en_out(WB_en_out), .Imm_out(Imm_out), .B_out(B_out),
    .SR_update_out(SR_update_out), .carry_out(carry_out),
    .valid_out(valid_out), .bubble_count(bubble_count)
  );

  id_ex_stage_reg #(.BUBBLE_CNT_WIDTH(2)) u_dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .pc_in(in_f.pc), .instruction_in(in_f.instr), .reg_file_dst_in(in_f.dst),
    .src1_in(in_f.s1), .src2_in(in_f.s2), .val_Rn_in(in_f.rn), .val_Rm_in(in_f.rm),
    .signed_immediate_in(in_f.simm), .shifter_operand_in(in_f.shop),
    .EX_command_in(in_f.ex), .mem_read_in(in_f.mr), .mem_write_in(in_f.mw),
    .WB_en_in(in_f.wb), .Imm_in(in_f.imm), .B_in(in_f.b), .SR_update_in(in_f.sr),
    .carry_in(in_f.c),
    .pc_out(s_pc), .instruction_out(s_instr), .reg_file_dst_out(s_dst),
    .src1_out(s_s1), .src2_out(s_s2), .val_Rn_out(s_rn), .val_Rm_out(s_rm),
    .signed_immediate_out(s_simm), .shifter_operand_out(s_shop),
    .EX_command_out(s_ex), .mem_read_out(s_mr), .mem_write_out(s_mw),
    .WB_en_out(s_wb), .Imm_out(s_imm), .B_out(s_b), .SR_update_out(s_sr),
    .carry_out(s_c), .valid_out(s_valid), .bubble_count(s_bubble_count)
  );

  // ---------------- scoreboard ----------------
  logic [BW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference state
  fields_t    m_f     = '0;
  logic       m_valid = 1'b0;
  logic [15:0] m_bc   = '0;
  logic [1:0] m_sat   = '0;

  // ---------------- driver ----------------
  // Apply controls (inputs already set in in_f), advance the reference, push
  // the expected bundle, then move to the next falling edge.
  task automatic step(input logic r, input logic f, input logic fz);
    rst    = r;
    flush  = f;
    freeze = fz;
    if (r) begin
      m_f = '0; m_valid = 1'b0; m_bc = '0; m_sat = '0;
    end else if (f) begin
      m_f = '0; m_valid = 1'b0;
      if (m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
      if (m_sat != 2'd3)    m_sat = m_sat + 2'd1;
    end else if (!fz) begin
      m_f = in_f;
`ifndef ID_EX_FORWARD_SRC_EN
      m_f.s1 = 4'h0;
      m_f.s2 = 4'h0;
`endif
      m_valid = 1'b1;
    end
    exp_q.push_back({m_f, m_valid, m_bc, m_sat});
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [BW-1:0] act;
    logic [BW-1:0] exp_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act = {pc_out, instruction_out, reg_file_dst_out, src1_out, src2_out,
               val_Rn_out, val_Rm_out, signed_immediate_out, shifter_operand_out,
               EX_command_out, mem_read_out, mem_write_out, WB_en_out, Imm_out,
               B_out, SR_update_out, carry_out, valid_out, bubble_count,
               s_bubble_count};
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL bundle#%0d actual=%h expected=%h (valid a/e=%b/%b bubbles a/e=%0d/%0d sat a/e=%0d/%0d pc a/e=%h/%h)",
                      n_checks, act, exp_v, valid_out, exp_v[18], bubble_count,
                      exp_v[17:2], s_bubble_count, exp_v[1:0], pc_out,
                      exp_v[BW-1 -: 32]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);

    // Reset with every input nonzero
    in_f = '{pc:32'hFFFF_0004, instr:32'hE3A0_1001, dst:4'h7, s1:4'h5, s2:4'h6,
             rn:32'h1234_5678, rm:32'h8765_4321, simm:24'hABCDEF, shop:12'hFFF,
             ex:4'hF, mr:1'b1, mw:1'b1, wb:1'b1, imm:1'b1, b:1'b1, sr:1'b1, c:1'b1};
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Load, then follow with changed inputs
    in_f = '0;
    in_f.pc = 32'h0000_0010; in_f.rn = 32'hDEAD_BEEF; in_f.ex = 4'b0010; in_f.wb = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    in_f = '{pc:32'h0000_0014, instr:32'hE082_1003, dst:4'h1, s1:4'h3, s2:4'hA,
             rn:32'h0000_0005, rm:32'hFFFF_FFFE, simm:24'h800001, shop:12'h003,
             ex:4'b1001, mr:1'b0, mw:1'b1, wb:1'b0, imm:1'b1, b:1'b0, sr:1'b1, c:1'b1};
    step(1'b0, 1'b0, 1'b0);
    // Condition-failed instruction: zero control bits, still valid
    in_f.pc = 32'h0000_0018; in_f.ex = 4'h0; in_f.mr = 1'b0; in_f.mw = 1'b0;
    in_f.wb = 1'b0; in_f.imm = 1'b0; in_f.b = 1'b0; in_f.sr = 1'b0;
    step(1'b0, 1'b0, 1'b0);

    // Freeze holds pc 0x10 across three changing inputs
    in_f.pc = 32'h0000_0010;
    step(1'b0, 1'b0, 1'b0);
    in_f.pc = 32'h0000_0014; step(1'b0, 1'b0, 1'b1);
    in_f.pc = 32'h0000_0018; step(1'b0, 1'b0, 1'b1);
    in_f.pc = 32'h0000_001C; step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Flush during freeze, then three more flushes
    in_f.wb = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    // Load and freeze keep the bubble count
    in_f.pc = 32'h0000_0100; in_f.c = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    in_f.pc = 32'h0000_0104;
    step(1'b0, 1'b0, 1'b1);

    // Reset during freeze discards held contents
    step(1'b1, 1'b0, 1'b1);

    // Saturation: five flushes from zero
    for (int i = 0; i < 5; i++) begin
      in_f.pc = 32'h0000_0200 + 32'(i * 4);
      step(1'b0, 1'b1, 1'b0);
    end

    // Forwarding sources and a few more patterns
    in_f = '0;
    in_f.s1 = 4'h3; in_f.s2 = 4'hA; in_f.pc = 32'h0000_0300;
    step(1'b0, 1'b0, 1'b0);
    in_f = '{pc:32'hAAAA_5554, instr:32'h5555_AAAA, dst:4'hE, s1:4'hF, s2:4'h0,
             rn:32'h8000_0000, rm:32'h7FFF_FFFF, simm:24'hFFFFFF, shop:12'h800,
             ex:4'b0100, mr:1'b1, mw:1'b0, wb:1'b1, imm:1'b0, b:1'b1, sr:1'b0, c:1'b0};
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain actual=%0d pending expected=0 pending", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Pipeline register between the instruction-decode stage and the execute stage of the 5-stage ARM-subset core.
- Each cycle it captures the decoded control bundle, operands, immediates and destination, plus the carry flag from the status register.
- Supports flush (bubble insertion on a taken branch) and freeze (hold on a hazard stall).
- Keeps a valid bit and a saturating bubble counter for debug.

Parameters:
- WORD_WIDTH, 32, data/PC/instruction width
- REG_FILE_DEPTH, 4, register address width
- SIGNED_IMM_WIDTH, 24, branch immediate width
- SHIFTER_OPERAND_WIDTH, 12, shifter operand width
- BUBBLE_CNT_WIDTH, 16, width of the bubble counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard the incoming instruction and load a bubble
- freeze  in  1  hold all stored state
- pc_in  in  WORD_WIDTH  PC of the decoded instruction
- instruction_in  in  WORD_WIDTH  raw instruction word
- reg_file_dst_in  in  REG_FILE_DEPTH  destination register
- src1_in, src2_in  in  REG_FILE_DEPTH each  source register addresses
- val_Rn_in, val_Rm_in  in  WORD_WIDTH each  register-file read data
- signed_immediate_in  in  SIGNED_IMM_WIDTH  branch offset
- shifter_operand_in  in  SHIFTER_OPERAND_WIDTH  shifter operand
- EX_command_in  in  4  ALU command
- mem_read_in, mem_write_in, WB_en_in, Imm_in, B_in, SR_update_in  in  1 each  control bits
- carry_in  in  1  status_register[1] (C flag) sampled this cycle
- Outputs: one registered copy of every *_in above, named with the *_out suffix; same widths.
- valid_out  out  1  1 = stored instruction is real, 0 = bubble
- bubble_count  out  BUBBLE_CNT_WIDTH  number of flush-inserted bubbles, saturating

Behaviour:
- Single clock domain.
- Update priority on each rising edge: rst > flush > freeze > load.

Reset (rst=1):
- Every *_out becomes 0.
- valid_out becomes 0.
- bubble_count becomes 0.
- A reset in the middle of a freeze discards the held contents.

Flush (rst=0, flush=1):
- All *_out become 0, including data fields; this keeps bubbles deterministic.
- valid_out becomes 0.
- bubble_count increments by 1 and saturates at all-ones.
- Flush overrides freeze when both are high.

Freeze (rst=0, flush=0, freeze=1):
- All outputs, valid_out and bubble_count hold their values.

Load (rst=0, flush=0, freeze=0):
- Every *_out takes its *_in value.
- valid_out becomes 1.
- bubble_count holds.

General rules:
- Latency is one cycle from *_in to *_out. There is no combinational path from input to output.
- A condition-failed instruction arrives with zeroed control bits. It is loaded as a normal instruction with valid_out=1; the register does not reinterpret it.
- Saturation: once bubble_count reaches 2^BUBBLE_CNT_WIDTH-1, further flushes leave it unchanged.

Optional Feature:
- Macro: ID_EX_FORWARD_SRC_EN.
- Defined: src1_out and src2_out are registered with the same priority rules as the other fields. The forwarding unit compares them against the MEM and WB destinations.
- Undefined: no src registers are instantiated; src1_out and src2_out are driven constant 0.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all inputs at nonzero values -> all outputs 0, valid_out=0, bubble_count=0.
- Load: pc_in=0x00000010, val_Rn_in=0xDEADBEEF, EX_command_in=4'b0010, WB_en_in=1 -> these values appear on the outputs one edge later with valid_out=1; change the inputs next cycle -> outputs follow with one cycle of latency.
- Freeze: load pc 0x10, then freeze=1 for 3 cycles with pc_in=0x14,0x18,0x1C -> pc_out stays 0x10 throughout; release freeze -> pc_out=0x1C.
- Flush during freeze: flush=1, freeze=1, WB_en_in=1 -> WB_en_out=0, valid_out=0, bubble_count=1. Three more flushes -> bubble_count=4.
- Saturation (BUBBLE_CNT_WIDTH=2): 5 consecutive flushes -> bubble_count reads 1,2,3,3,3.
- Forward sources, with ID_EX_FORWARD_SRC_EN defined: src1_in=4'h3, src2_in=4'hA -> src1_out=3, src2_out=A after one edge. With the macro undefined, both outputs stay 0.
